// File: rtl/conway_window_gen.sv
// conway_window_gen: streams a raster frame of 1-bit cells and emits each cell's 3x3 neighbourhood.
// Off-grid neighbours read as 0; two line buffers plus the incoming cell give one window per cycle.
module conway_window_gen #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_center,
    output logic [7:0]                m_neighbors,
    output logic [$clog2(HEIGHT)-1:0] m_row,
    output logic [$clog2(WIDTH)-1:0]  m_col,
    output logic                      m_last
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(HEIGHT);
    localparam int XW = $clog2(WIDTH);
    localparam int L  = 2 * WIDTH + 2;

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    state_t        state, state_nx;
    logic          armed;
    logic [CW-1:0] in_cnt, out_cnt;
    logic [L-1:0]  sr;
    logic [L:0]    v;
    logic [RW-1:0] nr;
    logic [XW-1:0] nc;
    logic [7:0]    nb;
    logic          s_hs, m_hs, load, top, bot, left, right;

    // v[0] is the south-east cell of the next window; in FLUSH a zero stands in for it
    always_comb begin
        m_hs     = m_valid && m_ready;
        s_ready  = armed && state != FLUSH && ((in_cnt - out_cnt) < CW'(WIDTH + 2) || m_hs);
        s_hs     = s_valid && s_ready;
        load     = state == FLUSH ? !m_valid || (m_ready && !m_last) : s_hs && in_cnt >= CW'(WIDTH + 1);
        v        = {sr, state == FLUSH ? 1'b0 : s_data};
        top      = nr == '0;
        bot      = nr == RW'(HEIGHT - 1);
        left     = nc == '0;
        right    = nc == XW'(WIDTH - 1);
        nb       = {v[0] && !bot && !right, v[1] && !bot, v[2] && !bot && !left,
                    v[WIDTH] && !right, v[WIDTH+2] && !left,
                    v[2*WIDTH] && !top && !right, v[2*WIDTH+1] && !top, v[2*WIDTH+2] && !top && !left};
        state_nx = state == FILL && s_hs && in_cnt == CW'(WIDTH + 1) ? STREAM :
                   state == STREAM && s_hs && in_cnt == CW'(N - 1) ? FLUSH :
                   state == FLUSH && m_hs && m_last ? FILL : state;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= FILL;
        else state <= state_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed       <= 1'b0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            sr          <= '0;
            nr          <= '0;
            nc          <= '0;
            m_valid     <= 1'b0;
            m_center    <= 1'b0;
            m_neighbors <= 8'h00;
            m_row       <= '0;
            m_col       <= '0;
            m_last      <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (state == FLUSH && m_hs && m_last) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (s_hs) in_cnt <= in_cnt + 1'b1;
                if (m_hs) out_cnt <= out_cnt + 1'b1;
            end
            if (s_hs || (state == FLUSH && load)) sr <= v[L-1:0];
            if (load) begin
                m_valid     <= 1'b1;
                m_center    <= v[WIDTH+1];
                m_neighbors <= nb;
                m_row       <= nr;
                m_col       <= nc;
                m_last      <= bot && right;
                nc          <= right ? '0 : nc + 1'b1;
                nr          <= right ? (bot ? '0 : nr + 1'b1) : nr;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conway_window_gen.sv
// tb_conway_window_gen: directed and backpressure tests on a 4x4 and an 8x8 instance.
module tb_conway_window_gen;
    logic clk = 1'b0, resetn = 1'b1;
    always #5 clk = ~clk;

    logic a_sv = 1'b0, a_sd = 1'b0, a_mr = 1'b0, a_sr, a_mv, a_mc, a_ml;
    logic [7:0] a_mn;
    logic [1:0] a_row, a_col;
    logic b_sv = 1'b0, b_sd = 1'b0, b_mr = 1'b0, b_sr, b_mv, b_mc, b_ml;
    logic [7:0] b_mn;
    logic [2:0] b_row, b_col;

    conway_window_gen #(.WIDTH(4), .HEIGHT(4)) dut4 (
        .clk(clk), .resetn(resetn), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .m_valid(a_mv), .m_ready(a_mr), .m_center(a_mc), .m_neighbors(a_mn),
        .m_row(a_row), .m_col(a_col), .m_last(a_ml));
    conway_window_gen #(.WIDTH(8), .HEIGHT(8)) dut8 (
        .clk(clk), .resetn(resetn), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .m_valid(b_mv), .m_ready(b_mr), .m_center(b_mc), .m_neighbors(b_mn),
        .m_row(b_row), .m_col(b_col), .m_last(b_ml));

    int checks = 0, errors = 0;
    logic [8:0] a_cap [16];
    int a_n, a_order_bad, a_last_bad;
    logic [63:0] b_frames [3];
    logic [8:0] b_cap [192];
    int b_ocyc [192];
    logic b_osr [192];
    int b_n, b_bad, b_unstable, b_over, b_order_bad, b_last_bad, b_turn_bad, b_stalls;
    int b_first_mv, b_hs9, b_hs_last;

    // Reference neighbourhood of (r,c) on an 8x8 frame: {neighbours, centre}
    function automatic logic [8:0] win8(input logic [63:0] f, input int r, input int c);
        logic [7:0] n;
        int p, rr, cc;
        for (int i = 0; i < 8; i++) begin
            p = i < 4 ? i : i + 1;
            rr = r + p / 3 - 1;
            cc = c + p % 3 - 1;
            n[i] = (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) ? f[rr*8+cc] : 1'b0;
        end
        return {n, f[r*8+c]};
    endfunction

    task automatic run_a(input logic [15:0] f);
        int ii, oo, cyc;
        ii = 0; oo = 0; cyc = 0; a_order_bad = 0; a_last_bad = 0;
        while (oo < 16 && cyc < 200) begin
            @(negedge clk);
            a_sv = ii < 16;
            a_sd = 1'b0;
            if (ii < 16) a_sd = f[ii];
            a_mr = 1'b1;
            #1;
            if (a_sv && a_sr) ii++;
            if (a_mv && a_mr) begin
                if ({a_row, a_col} != 4'(oo)) a_order_bad++;
                if (a_ml != (oo == 15)) a_last_bad++;
                a_cap[oo] = {a_mn, a_mc};
                oo++;
            end
            cyc++;
        end
        a_n = oo;
        a_sv = 1'b0;
    endtask

    task automatic run_b(input int nf, input bit rnd);
        int ii, oo, cyc, total, k;
        logic stalled, turn;
        logic [15:0] prev;
        ii = 0; oo = 0; cyc = 0; total = nf * 64; stalled = 0; turn = 0; prev = '0;
        b_bad = 0; b_unstable = 0; b_over = 0; b_order_bad = 0; b_last_bad = 0;
        b_turn_bad = 0; b_stalls = 0; b_first_mv = -1; b_hs9 = -1; b_hs_last = -1;
        while (oo < total && cyc < 5000) begin
            @(negedge clk);
            b_sv = ii < total && (!rnd || $urandom_range(0, 3) != 0);
            b_sd = 1'b0;
            if (ii < total) b_sd = b_frames[ii/64][ii%64];
            b_mr = !rnd || $urandom_range(0, 2) != 0;
            #1;
            if (turn && !b_sr) b_turn_bad++;
            turn = 0;
            if (stalled && {b_mc, b_mn, b_row, b_col, b_ml} !== prev) b_unstable++;
            stalled = b_mv && !b_mr;
            prev = {b_mc, b_mn, b_row, b_col, b_ml};
            if (stalled) b_stalls++;
            if (b_mv && b_first_mv < 0) b_first_mv = cyc;
            if (b_sv && b_sr) begin
                if (ii == 9) b_hs9 = cyc;
                if (ii == total - 1) b_hs_last = cyc;
                ii++;
            end
            if (b_mv && b_mr) begin
                k = oo % 64;
                if ({b_row, b_col} != 6'(k)) b_order_bad++;
                if (b_ml != (k == 63)) b_last_bad++;
                if ({b_mn, b_mc} !== win8(b_frames[oo/64], k / 8, k % 8)) b_bad++;
                b_cap[oo] = {b_mn, b_mc};
                b_ocyc[oo] = cyc;
                b_osr[oo] = b_sr;
                turn = b_ml;
                oo++;
            end
            if (ii - oo > 10) b_over++;
            cyc++;
        end
        b_n = oo;
        b_sv = 1'b0;
    endtask

    task automatic test_reset;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({a_sr, a_mv, a_mc, a_mn, a_row, a_col, a_ml} !== 16'h0) begin
            errors++; $display("FAIL reset4 got %h want 0", {a_sr, a_mv, a_mc, a_mn, a_row, a_col, a_ml});
        end
        checks++;
        if ({b_sr, b_mv, b_mc, b_mn, b_row, b_col, b_ml} !== 18'h0) begin
            errors++; $display("FAIL reset8 got %h want 0", {b_sr, b_mv, b_mc, b_mn, b_row, b_col, b_ml});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (a_sr !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", a_sr); end
        @(negedge clk);
        #1;
        checks++;
        if ({a_sr, b_sr} !== 2'b11) begin errors++; $display("FAIL ready_after_edge got %b want 11", {a_sr, b_sr}); end
        b_frames[0] = 64'hF0F0_3C3C_A5A5_0FF0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b_sv = 1'b1; b_sd = b_frames[0][i]; b_mr = 1'b1;
        end
        @(negedge clk);
        b_sv = 1'b0;
        #1;
        checks++;
        if (b_mv !== 1'b1) begin errors++; $display("FAIL midframe_valid got %b want 1", b_mv); end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({b_sr, b_mv, b_mc, b_mn, b_row, b_col, b_ml} !== 18'h0) begin
            errors++; $display("FAIL async_reset got %h want 0", {b_sr, b_mv, b_mc, b_mn, b_row, b_col, b_ml});
        end
        @(negedge clk);
        resetn = 1'b1;
        b_frames[0] = 64'h1234_5678_9ABC_DEF0;
        run_b(1, 0);
        checks++;
        if (b_n != 64 || b_order_bad != 0) begin
            errors++; $display("FAIL restart_order got n=%0d order_bad=%0d want 64/0", b_n, b_order_bad);
        end
        checks++;
        if (b_bad != 0) begin errors++; $display("FAIL restart_windows got %0d bad want 0", b_bad); end
    endtask

    task automatic test_single_cell;
        run_a(16'h0020);
        checks++;
        if (a_n != 16 || a_order_bad != 0) begin
            errors++; $display("FAIL single_order got n=%0d bad=%0d want 16/0", a_n, a_order_bad);
        end
        checks++;
        if (a_last_bad != 0) begin errors++; $display("FAIL single_last got %0d want 0", a_last_bad); end
        checks++;
        if (a_cap[0] !== {8'h80, 1'b0}) begin errors++; $display("FAIL single_00 got %h want %h", a_cap[0], {8'h80, 1'b0}); end
        checks++;
        if (a_cap[5] !== {8'h00, 1'b1}) begin errors++; $display("FAIL single_11 got %h want %h", a_cap[5], {8'h00, 1'b1}); end
        checks++;
        if (a_cap[10] !== {8'h01, 1'b0}) begin errors++; $display("FAIL single_22 got %h want %h", a_cap[10], {8'h01, 1'b0}); end
        checks++;
        if (a_cap[4] !== {8'h10, 1'b0}) begin errors++; $display("FAIL single_10 got %h want %h", a_cap[4], {8'h10, 1'b0}); end
    endtask

    task automatic test_all_live;
        run_a(16'hFFFF);
        checks++;
        if (a_n != 16) begin errors++; $display("FAIL live_count got %0d want 16", a_n); end
        checks++;
        if ({a_cap[0], a_cap[3], a_cap[12], a_cap[15]} !== {9'h1A1, 9'h0D1, 9'h02D, 9'h017}) begin
            errors++; $display("FAIL live_corners got %h %h %h %h want 1a1 0d1 02d 017", a_cap[0], a_cap[3], a_cap[12], a_cap[15]);
        end
        checks++;
        if (a_cap[5] !== 9'h1FF) begin errors++; $display("FAIL live_interior got %h want 1ff", a_cap[5]); end
        checks++;
        if ((a_cap[3][8:1] & 8'h94) !== 8'h00) begin errors++; $display("FAIL live_nowrap got %h want 00", a_cap[3][8:1] & 8'h94); end
    endtask

    task automatic test_latency;
        int bad;
        b_frames[0] = 64'hC3A5_0F1E_7788_2B4D;
        run_b(1, 0);
        checks++;
        if (b_n != 64 || b_bad != 0) begin errors++; $display("FAIL lat_windows got n=%0d bad=%0d want 64/0", b_n, b_bad); end
        checks++;
        if (b_first_mv != b_hs9 + 1) begin errors++; $display("FAIL lat_first got %0d want %0d", b_first_mv, b_hs9 + 1); end
        bad = 0;
        for (int k = 55; k < 64; k++)
            if (b_ocyc[k] != b_hs_last + k - 53 || b_osr[k] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL lat_drain got %0d bad want 0", bad); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 3; i++) b_frames[i] = {$urandom, $urandom};
        run_b(3, 1);
        checks++;
        if (b_n != 192 || b_bad != 0) begin errors++; $display("FAIL bp_windows got n=%0d bad=%0d want 192/0", b_n, b_bad); end
        checks++;
        if (b_unstable != 0 || b_stalls == 0) begin
            errors++; $display("FAIL bp_stable got unstable=%0d stalls=%0d want 0/>0", b_unstable, b_stalls);
        end
        checks++;
        if (b_over != 0) begin errors++; $display("FAIL bp_occupancy got %0d want 0", b_over); end
        checks++;
        if (b_order_bad != 0 || b_last_bad != 0) begin
            errors++; $display("FAIL bp_order got %0d/%0d want 0/0", b_order_bad, b_last_bad);
        end
        checks++;
        if (b_turn_bad != 0) begin errors++; $display("FAIL bp_turnaround got %0d want 0", b_turn_bad); end
    endtask

    task automatic test_glider;
        logic [63:0] nxt;
        int pc;
        b_frames[0] = 64'h0000_0000_0007_0402;
        run_b(1, 0);
        nxt = '0;
        for (int k = 0; k < 64; k++) begin
            pc = $countones(b_cap[k][8:1]);
            nxt[k] = pc == 3 || (b_cap[k][0] && pc == 2);
        end
        checks++;
        if (b_n != 64 || nxt !== 64'h0000_0000_0206_0500) begin
            errors++; $display("FAIL glider got %h n=%0d want 0000000002060500", nxt, b_n);
        end
    endtask

    initial begin
        test_reset;
        test_single_cell;
        test_all_live;
        test_latency;
        test_backpressure;
        test_glider;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
